// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port, byte-enabled SRAM (1-cycle
// read latency) among NumPorts request/grant requesters. Each granted access
// returns exactly one rvalid_o pulse to the port that issued it.
// Optional build macro SRAM_ARB_OUT_REG_EN: registers rdata_o and the response
// valid/index pipeline, so responses arrive 2 cycles after grant instead of 1.
module sram_port_arbiter #(
  parameter int unsigned NumPorts  = 3,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumPorts-1:0]                  req_i,
  input  logic [NumPorts-1:0]                  we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumPorts-1:0][DataWidth/8-1:0] be_i,
  output logic [NumPorts-1:0]                  gnt_o,
  output logic [NumPorts-1:0]                  rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 sram_req_o,
  output logic                                 sram_we_o,
  output logic [AddrWidth-1:0]                 sram_addr_o,
  output logic [DataWidth-1:0]                 sram_wdata_o,
  output logic [DataWidth/8-1:0]               sram_be_o,
  input  logic [DataWidth-1:0]                 sram_rdata_i
);

  localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [PtrW-1:0] rr_q, rr_d;
  logic [PtrW:0]   cand;
  logic [PtrW-1:0] gnt_idx;
  logic            gnt_any;

  logic            rsp_valid_q;
  logic [PtrW-1:0] rsp_idx_q;
  logic            rsp_out_valid;
  logic [PtrW-1:0] rsp_out_idx;

  // Grant: first requesting port in rr_q, rr_q+1, ... (mod NumPorts).
  // The candidate index is one bit wider than the pointer so rr_q+i can be
  // wrapped by a single conditional subtraction instead of a modulo.
  always_comb begin
    gnt_o   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      cand = {1'b0, rr_q} + (PtrW+1)'(i);
      if (cand >= (PtrW+1)'(NumPorts)) begin
        cand = cand - (PtrW+1)'(NumPorts);
      end
      if (!gnt_any && req_i[cand[PtrW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PtrW-1:0];
      end
    end
    if (gnt_any) begin
      gnt_o[gnt_idx] = 1'b1;
    end
  end

  // Next pointer: one past the winner with wrap, held when nobody is granted.
  always_comb begin
    rr_d = rr_q;
    if (gnt_any) begin
      rr_d = (gnt_idx == PtrW'(NumPorts - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // SRAM port mux: winner's fields go out the same cycle; all zero when idle.
  always_comb begin
    sram_req_o   = gnt_any;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (gnt_any) begin
      sram_we_o    = we_i[gnt_idx];
      sram_addr_o  = addr_i[gnt_idx];
      sram_wdata_o = wdata_i[gnt_idx];
      sram_be_o    = be_i[gnt_idx];
    end
  end

  // Response tracking: remember which port was granted, aligned with SRAM data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      rsp_valid_q <= gnt_any;
      rsp_idx_q   <= gnt_idx;
    end
  end

`ifdef SRAM_ARB_OUT_REG_EN
  logic                 out_valid_q;
  logic [PtrW-1:0]      out_idx_q;
  logic [DataWidth-1:0] rdata_q;

  // Output register stage: read data and its response tag move together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      rdata_q     <= '0;
    end else begin
      out_valid_q <= rsp_valid_q;
      out_idx_q   <= rsp_idx_q;
      rdata_q     <= sram_rdata_i;
    end
  end

  assign rsp_out_valid = out_valid_q;
  assign rsp_out_idx   = out_idx_q;
  assign rdata_o       = rdata_q;
`else
  assign rsp_out_valid = rsp_valid_q;
  assign rsp_out_idx   = rsp_idx_q;
  assign rdata_o       = sram_rdata_i;
`endif

  // Route the response-valid pulse back to the issuing port.
  always_comb begin
    rvalid_o = '0;
    if (rsp_out_valid) begin
      rvalid_o[rsp_out_idx] = 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM, a reference
// memory and a response scoreboard keyed on the expected response cycle.
module tb_sram_port_arbiter;

`ifdef SRAM_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst_ni;
  logic [2:0]       req, we;
  logic [2:0][9:0]  addr;
  logic [2:0][63:0] wdata;
  logic [2:0][7:0]  be;
  logic [2:0]       gnt_o, rvalid_o;
  logic [63:0]      rdata_o;
  logic             sram_req_o, sram_we_o;
  logic [9:0]       sram_addr_o;
  logic [63:0]      sram_wdata_o;
  logic [7:0]       sram_be_o;
  logic [63:0]      sram_rdata;

  sram_port_arbiter #(
    .NumPorts (3),
    .NumWords (1024),
    .DataWidth(64)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .be_i        (be),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .sram_req_o  (sram_req_o),
    .sram_we_o   (sram_we_o),
    .sram_addr_o (sram_addr_o),
    .sram_wdata_o(sram_wdata_o),
    .sram_be_o   (sram_be_o),
    .sram_rdata_i(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: byte-enabled write, registered read.
  logic [63:0] mem     [1024];
  logic [63:0] ref_mem [1024];
  always @(posedge clk) begin
    if (sram_req_o) begin
      for (int b = 0; b < 8; b++) begin
        if (sram_we_o && sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end
      sram_rdata <= mem[sram_addr_o];
    end
  end

  typedef struct {
    int          port;
    logic        rd;
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic w, input logic [9:0] a,
                          input logic [63:0] d, input logic [7:0] b);
    we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
  endtask

  task automatic push(input int p);
    exp_t e;
    e.port = p;
    e.rd   = !we[p];
    e.data = ref_mem[addr[p]];
    e.due  = cyc + LAT;
    if (we[p]) begin
      for (int b = 0; b < 8; b++)
        if (be[p][b]) ref_mem[addr[p]][8*b +: 8] = wdata[p][8*b +: 8];
    end
    sbq.push_back(e);
  endtask

  logic [2:0] last_gnt;

  // Called at posedge+1; checks the combinational grant and SRAM side, then
  // advances to posedge+1 of the next cycle.
  task automatic step(input logic [2:0] r, input logic [2:0] exp_gnt, input string tag);
    int p;
    req = r;
    #1;
    last_gnt = gnt_o;
    chk({tag, ":gnt"}, 64'(gnt_o), 64'(exp_gnt));
    chk({tag, ":sram_req"}, 64'(sram_req_o), 64'(exp_gnt != 3'b000));
    if (exp_gnt != 3'b000) begin
      p = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
      chk({tag, ":sram_addr"}, 64'(sram_addr_o), 64'(addr[p]));
      chk({tag, ":sram_we"}, 64'(sram_we_o), 64'(we[p]));
      chk({tag, ":sram_be"}, 64'(sram_be_o), 64'(be[p]));
      if (we[p]) chk({tag, ":sram_wdata"}, sram_wdata_o, wdata[p]);
      push(p);
    end else begin
      chk({tag, ":sram_be_idle"}, 64'(sram_be_o), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: rvalid_o must match the scoreboard head exactly on its
  // due cycle and be zero otherwise.
  always @(negedge clk) begin : mon
    logic [2:0] exp_rv;
    exp_rv = 3'b000;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_rv[sbq[0].port] = 1'b1;
      chk("rvalid", 64'(rvalid_o), 64'(exp_rv));
      if (sbq[0].rd) chk("rdata", rdata_o, sbq[0].data);
      void'(sbq.pop_front());
    end else begin
      chk("rvalid_quiet", 64'(rvalid_o), 64'(exp_rv));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  int gcount [3];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    sram_rdata = '0;
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    @(posedge clk); #1;

    // Reset: grant follows req with pointer 0; no responses.
    set_port(1, 1'b0, 10'h001, '0, 8'hFF);
    set_port(2, 1'b0, 10'h002, '0, 8'hFF);
    req = 3'b110;
    #1;
    chk("rst:gnt", 64'(gnt_o), 64'(3'b010));
    chk("rst:rvalid", 64'(rvalid_o), 64'd0);
`ifdef SRAM_ARB_OUT_REG_EN
    chk("rst:rdata", rdata_o, 64'd0);
`endif
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Fairness: all three read continuously from reset.
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 10'(100 + p), '0, 8'hFF);
    for (int i = 0; i < 12; i++) begin
      step(3'b111, 3'(1 << (i % 3)), "fair");
      for (int p = 0; p < 3; p++) gcount[p] += int'(last_gnt[p]);
    end
    for (int p = 0; p < 3; p++) chk("fair:count", 64'(gcount[p]), 64'd4);

    // Single read after write (pointer at 0).
    set_port(0, 1'b1, 10'h010, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    step(3'b001, 3'b001, "wr010");
    set_port(1, 1'b0, 10'h010, '0, 8'hFF);
    step(3'b010, 3'b010, "rd010");
    req = '0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    chk("rd010:rvalid", 64'(rvalid_o), 64'(3'b010));
    chk("rd010:rdata", rdata_o, 64'hDEAD_BEEF_0123_4567);
    @(posedge clk); #1;

    // Byte enables (pointer at 2).
    set_port(2, 1'b1, 10'd5, '1, 8'hFF);
    step(3'b100, 3'b100, "be_ones");
    set_port(0, 1'b1, 10'd5, '0, 8'h0F);
    step(3'b001, 3'b001, "be_lo");
    set_port(1, 1'b0, 10'd5, '0, 8'hFF);
    step(3'b010, 3'b010, "be_rd");
    req = '0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    chk("be_rd:rvalid", 64'(rvalid_o), 64'(3'b010));
    chk("be_rd:rdata", rdata_o, 64'hFFFF_FFFF_0000_0000);
    @(posedge clk); #1;

    // Pointer skip/wrap (pointer at 2).
    set_port(0, 1'b0, 10'd7, '0, 8'hFF);
    set_port(2, 1'b0, 10'd8, '0, 8'hFF);
    step(3'b001, 3'b001, "skip");
    step(3'b101, 3'b100, "wrap");

    // Back-to-back grants to a lone requester; responses overlap new grants.
    set_port(1, 1'b1, 10'd9, 64'h0123_4567_89AB_CDEF, 8'h3C);
    step(3'b010, 3'b010, "b2b0");
    set_port(1, 1'b0, 10'd9, '0, 8'hFF);
    step(3'b010, 3'b010, "b2b1");
    step(3'b010, 3'b010, "b2b2");

    // Idle: nothing issued, pointer (2) must hold.
    for (int i = 0; i < 10; i++) step(3'b000, 3'b000, "idle");
    step(3'b111, 3'b100, "post_idle0");
    step(3'b111, 3'b001, "post_idle1");

    // Reset mid-flight: read granted to port 2, reset before its response.
    req = 3'b100;
    #1;
    chk("mid:gnt", 64'(gnt_o), 64'(3'b100));
    #2;
    rst_ni = 1'b0;
    req = '0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) step(3'b000, 3'b000, "post_rst_quiet");
    step(3'b111, 3'b001, "post_rst0");
    step(3'b111, 3'b010, "post_rst1");

    // Drain outstanding responses.
    req = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("drain:sbq", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
